// File: rtl/licznik_czasu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : licznik_pkg
//  Description : Shared definitions for the RTC timekeeping core: mode
//                encoding, packed-BCD constants and the 2-digit BCD
//                increment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package licznik_pkg;

    localparam logic [1:0] MODE_RUN      = 2'b00;
    localparam logic [1:0] MODE_SET_HOUR = 2'b01;
    localparam logic [1:0] MODE_SET_MIN  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = MODE_RUN,
        ST_SET_HOUR = MODE_SET_HOUR,
        ST_SET_MIN  = MODE_SET_MIN
    } state_t;

    localparam logic [7:0] BCD_ZERO     = 8'h00;
    localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
    localparam logic [7:0] BCD_MIN_MAX  = 8'h59;

    // Returns {wrap, next}. wrap is set when val already sits at max, in
    // which case next is 00; otherwise next is val + 1 with a decimal carry
    // from the low digit into the high digit.
    function automatic logic [8:0] bcd_inc(input logic [7:0] val,
                                           input logic [7:0] max);
        logic [8:0] res;
        if (val == max)
            res = {1'b1, BCD_ZERO};
        else if (val[3:0] == 4'h9)
            res = {1'b0, val[7:4] + 4'h1, 4'h0};
        else
            res = {1'b0, val[7:4], val[3:0] + 4'h1};
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/licznik_czasu_if.sv
`default_nettype none
// ============================================================================
//  Module      : licznik_czasu_if
//  Description : Signal bundle between the timekeeping core and its
//                surroundings.
//                Inputs : div_clk (1 s divided clock), set_i, inc_i (buttons)
//                Outputs: sec_o/min_o/hour_o (packed BCD), mode_o, day_o
//                master = environment side, slave = core side.
//  Revision    : 1.0  initial release
// ============================================================================
interface licznik_czasu_if;
    logic       div_clk;
    logic       set_i;
    logic       inc_i;
    logic [7:0] sec_o;
    logic [7:0] min_o;
    logic [7:0] hour_o;
    logic [1:0] mode_o;
    logic       day_o;

    modport master (
        output div_clk, set_i, inc_i,
        input  sec_o, min_o, hour_o, mode_o, day_o
    );

    modport slave (
        input  div_clk, set_i, inc_i,
        output sec_o, min_o, hour_o, mode_o, day_o
    );
endinterface
`default_nettype wire

// File: rtl/licznik_czasu_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : licznik_bcd
//  Description : Two-digit packed-BCD register that counts 00..max_i.
//                clk_i, rst_i (async, active low), clr_i (sync clear to 00,
//                dominates inc_i), inc_i (advance by one with wrap),
//                max_i (last valid value), val_o (current value),
//                wrap_o (value sits at max_i, so an increment would wrap).
//  Revision    : 1.0  initial release
// ============================================================================
module licznik_bcd
    import licznik_pkg::*;
(
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    input  wire logic       clr_i,
    input  wire logic       inc_i,
    input  wire logic [7:0] max_i,
    output logic      [7:0] val_o,
    output logic            wrap_o
);

    logic [7:0] r_val;
    logic [8:0] w_inc_res;

    assign w_inc_res = bcd_inc(r_val, max_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_val <= BCD_ZERO;
        else if (clr_i)
            r_val <= BCD_ZERO;
        else if (inc_i)
            r_val <= w_inc_res[7:0];
    end

    // Ungated by inc_i so the parent can build its carry chain without a
    // combinational loop back through this module.
    assign wrap_o = w_inc_res[8];
    assign val_o  = r_val;

endmodule
`default_nettype wire

// File: rtl/licznik_czasu.sv
`default_nettype none
// ============================================================================
//  Module      : licznik_czasu
//  Description : RTC timekeeping core. Converts each rising edge of div_clk
//                into a 1 s tick and keeps hh:mm:ss in packed BCD (24 h),
//                with a set/inc button mode for hours and minutes.
//                clk_i  : system clock
//                rst_i  : asynchronous reset, active low
//                bus    : div_clk/set_i/inc_i in, sec/min/hour/mode/day out
//  Revision    : 1.0  initial release
// ============================================================================
module licznik_czasu
    import licznik_pkg::*;
#(
    parameter logic [7:0] HOUR_MAX = BCD_HOUR_MAX,
    parameter logic [7:0] MIN_MAX  = BCD_MIN_MAX
)
(
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    licznik_czasu_if.slave   bus
);

    // Delayed copies for rising-edge detection
    logic   r_div_q, r_set_q, r_inc_q;
    logic   w_tick, w_set, w_inc;

    state_t r_state, w_state_next;
    logic   r_day, w_day_next;

    logic   w_sec_clr, w_sec_inc, w_min_inc, w_hour_inc;
    logic   w_sec_wrap, w_min_wrap, w_hour_wrap;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_div_q <= 1'b0;
            r_set_q <= 1'b0;
            r_inc_q <= 1'b0;
        end else begin
            r_div_q <= bus.div_clk;
            r_set_q <= bus.set_i;
            r_inc_q <= bus.inc_i;
        end
    end

    // Pulses are combinational from the live input so the counters move on
    // the very edge that first samples the input high.
    assign w_tick = bus.div_clk & ~r_div_q;
    assign w_set  = bus.set_i   & ~r_set_q;
    assign w_inc  = bus.inc_i   & ~r_inc_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_RUN;
            r_day   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_day   <= w_day_next;
        end
    end

    // A set pulse always takes priority over a tick or an inc on the same edge.
    always_comb begin
        w_state_next = r_state;
        w_sec_clr    = 1'b0;
        w_sec_inc    = 1'b0;
        w_min_inc    = 1'b0;
        w_hour_inc   = 1'b0;
        w_day_next   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_set) begin
                    w_state_next = ST_SET_HOUR;
                    w_sec_clr    = 1'b1;
                end else if (w_tick) begin
                    w_sec_inc  = 1'b1;
                    w_min_inc  = w_sec_wrap;
                    w_hour_inc = w_sec_wrap & w_min_wrap;
                    w_day_next = w_sec_wrap & w_min_wrap & w_hour_wrap;
                end
            end
            ST_SET_HOUR: begin
                if (w_set)
                    w_state_next = ST_SET_MIN;
                else if (w_inc)
                    w_hour_inc = 1'b1;
            end
            ST_SET_MIN: begin
                if (w_set)
                    w_state_next = ST_RUN;
                else if (w_inc)
                    w_min_inc = 1'b1;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    licznik_bcd u_sec (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_sec_clr),
        .inc_i  (w_sec_inc),
        .max_i  (MIN_MAX),
        .val_o  (bus.sec_o),
        .wrap_o (w_sec_wrap)
    );

    licznik_bcd u_min (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (1'b0),
        .inc_i  (w_min_inc),
        .max_i  (MIN_MAX),
        .val_o  (bus.min_o),
        .wrap_o (w_min_wrap)
    );

    licznik_bcd u_hour (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (1'b0),
        .inc_i  (w_hour_inc),
        .max_i  (HOUR_MAX),
        .val_o  (bus.hour_o),
        .wrap_o (w_hour_wrap)
    );

    assign bus.mode_o = r_state;
    assign bus.day_o  = r_day;

endmodule
`default_nettype wire

// File: tb/tb_licznik_czasu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_licznik_czasu
//  Description : Self-checking bench for licznik_czasu. A directed vector
//                table covers edge detection, set mode and collisions; a
//                seconds-of-day reference model feeds a scoreboard for the
//                long sequences (counting, rollover, set, reset).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_licznik_czasu;
    import licznik_pkg::*;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
        logic [1:0] mode;
        logic       day;
    } exp_t;

    typedef struct {
        bit   d;
        bit   s;
        bit   i;
        exp_t e;
    } vec_t;

    logic clk;
    logic rst;
    licznik_czasu_if bus ();

    licznik_czasu dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    string phase = "init";
    exp_t  sb[$];

    // Reference model: plain integers, time advanced as seconds-of-day
    int       m_h, m_m, m_s;
    logic [1:0] m_mode;
    bit       m_day;
    bit       pd, ps, pi;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic exp_t model_exp();
        return '{to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), m_mode, m_day};
    endfunction

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_mode = MODE_RUN; m_day = 0;
        pd = 0; ps = 0; pi = 0;
    endtask

    task automatic model_step(input bit d, input bit s, input bit i);
        bit tp, sp, ip;
        int tot;
        tp = d & !pd; sp = s & !ps; ip = i & !pi;
        m_day = 0;
        if (m_mode == MODE_RUN) begin
            if (sp) begin
                m_mode = MODE_SET_HOUR;
                m_s = 0;
            end else if (tp) begin
                tot = m_h * 3600 + m_m * 60 + m_s + 1;
                if (tot == 86400) begin
                    tot = 0;
                    m_day = 1;
                end
                m_h = tot / 3600;
                m_m = (tot / 60) % 60;
                m_s = tot % 60;
            end
        end else if (m_mode == MODE_SET_HOUR) begin
            if (sp) m_mode = MODE_SET_MIN;
            else if (ip) m_h = (m_h + 1) % 24;
        end else begin
            if (sp) m_mode = MODE_RUN;
            else if (ip) m_m = (m_m + 1) % 60;
        end
        pd = d; ps = s; pi = i;
    endtask

    task automatic compare(input exp_t e, input string what);
        exp_t a;
        a = '{bus.hour_o, bus.min_o, bus.sec_o, bus.mode_o, bus.day_o};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h:%h:%h mode=%b day=%b, want %h:%h:%h mode=%b day=%b",
                     what, a.hour, a.min, a.sec, a.mode, a.day,
                     e.hour, e.min, e.sec, e.mode, e.day);
        end
    endtask

    task automatic check_out();
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", phase);
        end else begin
            compare(sb.pop_front(), phase);
        end
    endtask

    // One clock: drive at negedge, record expectation, check after posedge
    task automatic apply(input bit d, input bit s, input bit i,
                         input bit has_ov, input exp_t ov);
        @(negedge clk);
        bus.div_clk = d; bus.set_i = s; bus.inc_i = i;
        model_step(d, s, i);
        sb.push_back(has_ov ? ov : model_exp());
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic step(input bit d, input bit s, input bit i);
        apply(d, s, i, 1'b0, '0);
    endtask

    task automatic tick();   step(1, 0, 0); step(0, 0, 0); endtask
    task automatic inc_n(input int n);
        for (int k = 0; k < n; k++) begin
            step(0, 0, 1); step(0, 0, 0);
        end
    endtask
    task automatic press_set(); step(0, 1, 0); step(0, 0, 0); endtask

    // Async reset: outputs must clear before any clock edge. The first edge
    // after release is checked with div_clk at the requested level.
    task automatic do_reset(input bit div_at_release);
        @(negedge clk);
        #2;
        rst = 1'b0;
        bus.div_clk = div_at_release; bus.set_i = 1'b0; bus.inc_i = 1'b0;
        #1;
        compare('{8'h00, 8'h00, 8'h00, MODE_RUN, 1'b0}, {phase, " async reset"});
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_step(div_at_release, 1'b0, 1'b0);
        sb.push_back(model_exp());
        @(posedge clk);
        #1;
        check_out();
    endtask

    vec_t tbl[22];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // {d, s, i, {hour, min, sec, mode, day}} from a fresh reset
        tbl[0]  = '{0, 0, 0, '{8'h00, 8'h00, 8'h00, MODE_RUN,      1'b0}};
        tbl[1]  = '{1, 0, 0, '{8'h00, 8'h00, 8'h01, MODE_RUN,      1'b0}};
        tbl[2]  = '{1, 0, 0, '{8'h00, 8'h00, 8'h01, MODE_RUN,      1'b0}};
        tbl[3]  = '{0, 0, 0, '{8'h00, 8'h00, 8'h01, MODE_RUN,      1'b0}};
        tbl[4]  = '{1, 0, 1, '{8'h00, 8'h00, 8'h02, MODE_RUN,      1'b0}};
        tbl[5]  = '{0, 0, 0, '{8'h00, 8'h00, 8'h02, MODE_RUN,      1'b0}};
        tbl[6]  = '{0, 1, 0, '{8'h00, 8'h00, 8'h00, MODE_SET_HOUR, 1'b0}};
        tbl[7]  = '{0, 0, 1, '{8'h01, 8'h00, 8'h00, MODE_SET_HOUR, 1'b0}};
        tbl[8]  = '{1, 0, 0, '{8'h01, 8'h00, 8'h00, MODE_SET_HOUR, 1'b0}};
        tbl[9]  = '{0, 1, 1, '{8'h01, 8'h00, 8'h00, MODE_SET_MIN,  1'b0}};
        tbl[10] = '{0, 0, 0, '{8'h01, 8'h00, 8'h00, MODE_SET_MIN,  1'b0}};
        tbl[11] = '{0, 0, 1, '{8'h01, 8'h01, 8'h00, MODE_SET_MIN,  1'b0}};
        tbl[12] = '{0, 0, 1, '{8'h01, 8'h01, 8'h00, MODE_SET_MIN,  1'b0}};
        tbl[13] = '{0, 1, 0, '{8'h01, 8'h01, 8'h00, MODE_RUN,      1'b0}};
        tbl[14] = '{1, 0, 0, '{8'h01, 8'h01, 8'h01, MODE_RUN,      1'b0}};
        tbl[15] = '{0, 0, 0, '{8'h01, 8'h01, 8'h01, MODE_RUN,      1'b0}};
        tbl[16] = '{1, 1, 0, '{8'h01, 8'h01, 8'h00, MODE_SET_HOUR, 1'b0}};
        tbl[17] = '{0, 0, 0, '{8'h01, 8'h01, 8'h00, MODE_SET_HOUR, 1'b0}};
        tbl[18] = '{0, 1, 0, '{8'h01, 8'h01, 8'h00, MODE_SET_MIN,  1'b0}};
        tbl[19] = '{0, 0, 0, '{8'h01, 8'h01, 8'h00, MODE_SET_MIN,  1'b0}};
        tbl[20] = '{0, 1, 0, '{8'h01, 8'h01, 8'h00, MODE_RUN,      1'b0}};
        tbl[21] = '{0, 0, 0, '{8'h01, 8'h01, 8'h00, MODE_RUN,      1'b0}};

        rst = 1'b1;
        bus.div_clk = 1'b0; bus.set_i = 1'b0; bus.inc_i = 1'b0;
        model_reset();

        phase = "table";
        do_reset(0);
        for (int k = 0; k < 22; k++) begin
            phase = $sformatf("table[%0d]", k);
            apply(tbl[k].d, tbl[k].s, tbl[k].i, 1'b1, tbl[k].e);
        end

        // Seconds counting with decimal carry
        phase = "seconds";
        do_reset(0);
        for (int k = 0; k < 9; k++) tick();
        compare('{8'h00, 8'h00, 8'h09, MODE_RUN, 1'b0}, "sec 09");
        tick();
        compare('{8'h00, 8'h00, 8'h10, MODE_RUN, 1'b0}, "sec 10");
        for (int k = 0; k < 50; k++) tick();
        compare('{8'h00, 8'h01, 8'h00, MODE_RUN, 1'b0}, "60 ticks");

        // Day rollover
        phase = "rollover";
        do_reset(0);
        press_set(); inc_n(23);
        press_set(); inc_n(59);
        press_set();
        compare('{8'h23, 8'h59, 8'h00, MODE_RUN, 1'b0}, "load 23:59");
        for (int k = 0; k < 59; k++) tick();
        compare('{8'h23, 8'h59, 8'h59, MODE_RUN, 1'b0}, "23:59:59");
        step(1, 0, 0);
        compare('{8'h00, 8'h00, 8'h00, MODE_RUN, 1'b1}, "midnight day pulse");
        step(0, 0, 0);
        compare('{8'h00, 8'h00, 8'h00, MODE_RUN, 1'b0}, "day pulse one cycle");

        // Set mode with wrap and discarded ticks
        phase = "set";
        do_reset(0);
        press_set();
        for (int k = 0; k < 25; k++) begin
            step(0, 0, 1); step(0, 0, 0);
            if (k % 5 == 0) tick();
        end
        compare('{8'h01, 8'h00, 8'h00, MODE_SET_HOUR, 1'b0}, "hour x25");
        press_set();
        for (int k = 0; k < 61; k++) begin
            step(0, 0, 1); step(0, 0, 0);
            if (k % 7 == 0) tick();
        end
        compare('{8'h01, 8'h01, 8'h00, MODE_SET_MIN, 1'b0}, "min x61");
        press_set();
        tick();
        compare('{8'h01, 8'h01, 8'h01, MODE_RUN, 1'b0}, "run after set");

        // Collisions and held levels
        phase = "collide";
        step(0, 1, 1); step(0, 0, 0);
        compare('{8'h01, 8'h01, 8'h00, MODE_SET_HOUR, 1'b0}, "set+inc hour");
        step(0, 1, 1); step(0, 0, 0);
        compare('{8'h01, 8'h01, 8'h00, MODE_SET_MIN, 1'b0}, "set+inc min");
        press_set();
        for (int k = 0; k < 50; k++) step(1, 0, 0);
        step(0, 0, 0);
        compare('{8'h01, 8'h01, 8'h01, MODE_RUN, 1'b0}, "div held 50");
        step(1, 1, 0);
        compare('{8'h01, 8'h01, 8'h00, MODE_SET_HOUR, 1'b0}, "set+tick");
        step(0, 0, 0);

        // Reset while in SET_MIN with div_clk high at release
        phase = "midreset";
        do_reset(0);
        press_set(); inc_n(12);
        press_set(); inc_n(34);
        compare('{8'h12, 8'h34, 8'h00, MODE_SET_MIN, 1'b0}, "at 12:34");
        do_reset(1);
        compare('{8'h00, 8'h00, 8'h01, MODE_RUN, 1'b0}, "first edge after release");
        step(1, 0, 0);
        step(0, 0, 0);
        compare('{8'h00, 8'h00, 8'h01, MODE_RUN, 1'b0}, "held after release");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
